coef_frame_loader: RTL
======================

// Module: coef_frame_loader
// PURPOSE
//   Host-side producer for the lookahead IIR filter's coefficient interface.
//   - Receives coefficient frames as a word stream (valid/ready/last).
//   - Assembles nine Q(WHOLE_BITS).(FRAC_BITS) coefficients into a shadow bank.
//   - Atomically commits the shadow bank to the filter's coefficient inputs.
//   - Drives coefficients_ready, pulsing it low for one cycle so the filter
//     flushes its state on every coefficient change.
// PARAMETERS
//   WHOLE_BITS = 10  integer bits of each coefficient (two's complement)
//   FRAC_BITS  = 54  fractional bits of each coefficient
//   WIDTH      = 64  WHOLE_BITS+FRAC_BITS; coefficient width
//   WORD_BITS  = 16  stream word width; WIDTH % WORD_BITS must be 0
//   (local) WPC = WIDTH/WORD_BITS words per coefficient; FRAME_WORDS = 9*WPC
// PORTS
//   clk                input   1          single clock, rising edge
//   reset_n            input   1          asynchronous, active-low reset
//   s_data             input   WORD_BITS  frame word
//   s_valid            input   1          s_data valid
//   s_last             input   1          final word of frame (qualified by s_valid)
//   s_ready            output  1          loader accepts the word this cycle
//   b0..b6, a3, a6     output  WIDTH      active coefficient bank (each port)
//   coefficients_ready output  1          active bank valid; low forces filter reset
//   load_error         output  1          one-cycle pulse: frame rejected
//   busy               output  1          frame in progress (state != IDLE)
// BEHAVIOUR
//   - Reset: all coefficient outputs 0, coefficients_ready=0, load_error=0,
//     busy=0, state=IDLE. s_ready becomes 1 on the first cycle after release.
//   - A word is transferred on a rising edge with s_valid & s_ready. s_valid
//     gaps are legal and stall the word counter.
//   - Frame order: b0,b1,b2,b3,b4,b5,b6,a3,a6. Each coefficient is sent as WPC
//     words, least-significant word first. Words go only to the shadow bank.
//   - States: IDLE, LOAD, COMMIT, DRAIN.
//     IDLE->LOAD on the first accepted word. Words accepted in IDLE count.
//     LOAD: word counter 0..FRAME_WORDS-1 (plus checksum word if enabled).
//     Last expected word with s_last=1 -> COMMIT.
//     s_last=1 before the last expected word -> IDLE, load_error pulse.
//     Last expected word with s_last=0 -> DRAIN.
//     DRAIN: s_ready=1; words are discarded until s_last, then IDLE with a
//     load_error pulse.
//     COMMIT: s_ready=0 for exactly one cycle. On its edge the active bank
//     takes the shadow bank and coefficients_ready goes to 0. On the next edge
//     coefficients_ready goes to 1 and state returns to IDLE.
//   - Timing: last word at edge E0 -> outputs change and coefficients_ready=0
//     at E1 -> coefficients_ready=1 at E2. The first commit after reset takes
//     coefficients_ready 0->0->1.
//   - A rejected frame never alters the active bank or coefficients_ready.
//     The shadow bank is don't-care.
//   - A single-word frame with s_last=1 is an early-last error (FRAME_WORDS>1).
//   - reset_n asserted mid-frame or in COMMIT: immediate return to reset values.
//     A partial frame is lost.
// CONFIGURATION
//   COEF_LOADER_CHECKSUM_EN
//   - Defined: the frame carries one extra trailing word, the XOR of all
//     FRAME_WORDS data words; s_last belongs on that word. The XOR accumulates
//     during LOAD. A mismatch on the checksum word -> IDLE plus load_error,
//     with no commit.
//   - Undefined: no checksum word; s_last belongs on data word FRAME_WORDS-1.
// STRUCTURE
//   - Package coef_loader_pkg:
//     - coef_idx_e enum {B0..B6,A3,A6}
//     - NUM_COEF=9
//     - loader_state_e {IDLE,LOAD,COMMIT,DRAIN}
//   - One sub-module, coef_shadow_bank:
//     - shadow array written by word index (coef = cnt/WPC, slice = cnt%WPC)
//     - active array loaded on a commit strobe
//   - The top level holds the FSM, word counter, checksum and handshake.
// TESTING
//   1 Reset: reset_n=0 mid-operation -> all coefs 0, coefficients_ready=0,
//     busy=0. After release, s_ready=1.
//   2 Good frame, 36 words: b0=64'h0040_0000_0000_0000 (1.0),
//     a3=64'hFFE0_0000_0000_0000 (-0.5), all others 0, back-to-back valid ->
//     outputs update at E1, coefficients_ready low for exactly one cycle,
//     s_ready=0 for that COMMIT cycle only.
//   3 Same frame with random s_valid gaps -> same final bank. Reload with b1=1.0
//     -> b0 is retained as 1.0 only if it is resent.
//   4 Early s_last on word 20 -> one load_error pulse, bank and
//     coefficients_ready unchanged, next good frame commits.
//   5 Missing s_last (40 words, last on word 40) -> DRAIN discards 4 words,
//     then load_error, no commit.
//   6 With COEF_LOADER_CHECKSUM_EN: corrupt checksum -> load_error, no commit.
//     Correct checksum on word 37 -> commit as in test 2.

Source files
------------

// File: rtl/coef_loader_pkg.sv
// coef_loader_pkg
//   Shared types for the coefficient frame loader.
//   - coef_idx_e     : coefficient slot order; this is also the order the
//                      coefficients arrive in a frame
//   - NUM_COEF       : number of coefficients in one bank
//   - loader_state_e : frame loader FSM states
//   - words_per_coef : stream words needed to carry one coefficient
package coef_loader_pkg;

  localparam int NUM_COEF = 9;

  typedef enum logic [3:0] {
    B0 = 4'd0,
    B1 = 4'd1,
    B2 = 4'd2,
    B3 = 4'd3,
    B4 = 4'd4,
    B5 = 4'd5,
    B6 = 4'd6,
    A3 = 4'd7,
    A6 = 4'd8
  } coef_idx_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } loader_state_e;

  function automatic int unsigned words_per_coef(input int unsigned width,
                                                 input int unsigned word_bits);
    return width / word_bits;
  endfunction

endpackage

// File: rtl/coef_shadow_bank.sv
// coef_shadow_bank
//   Shadow coefficient bank filled one stream word at a time, plus the active
//   bank that the filter sees. The active bank only changes on commit, so a
//   frame in progress never disturbs the running filter.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : write wr_data into the shadow bank at word index wr_idx
//   wr_idx       : frame word index; coef = idx / WPC, slice = idx % WPC
//   wr_data      : stream word (slice 0 is the least-significant word)
//   commit       : copy the whole shadow bank into the active bank
//   active       : active bank, one WIDTH-bit entry per coefficient
module coef_shadow_bank
  import coef_loader_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int WORD_BITS = 16,
  parameter int IDX_W     = 6
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [WORD_BITS-1:0]                wr_data,
  input  logic                                commit,
  output logic [NUM_COEF-1:0][WIDTH-1:0]      active
);

  localparam int unsigned WPC  = words_per_coef(WIDTH, WORD_BITS);
  localparam int unsigned CI_W = $clog2(NUM_COEF);
  localparam int unsigned SL_W = (WPC > 1) ? $clog2(WPC) : 1;

  // Packed [coef][slice][bit]: slice 0 lands in the low bits, so the whole
  // array has the same layout as the active bank and copies across directly.
  logic [NUM_COEF-1:0][WPC-1:0][WORD_BITS-1:0] shadow;

  int unsigned      idx;
  logic [CI_W-1:0]  coef_sel;
  logic [SL_W-1:0]  slice_sel;

  always_comb begin
    idx       = 32'(wr_idx);
    coef_sel  = CI_W'(idx / WPC);
    slice_sel = SL_W'(idx % WPC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en) begin
        shadow[coef_sel][slice_sel] <= wr_data;
      end
      if (commit) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: rtl/coef_frame_loader.sv
// coef_frame_loader
//   Receives coefficient frames over a valid/ready/last word stream, assembles
//   nine coefficients in a shadow bank and commits them atomically to the IIR
//   filter. coefficients_ready drops for one cycle on every commit so the
//   filter flushes its state whenever its coefficients change.
// Ports
//   clk, reset_n       : clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready     : frame word stream (word moves on s_valid & s_ready)
//   b0..b6, a3, a6     : active coefficient bank
//   coefficients_ready : active bank valid; low forces a filter reset
//   load_error         : one-cycle pulse when a frame is rejected
//   busy               : frame in progress
// Configuration
//   COEF_LOADER_CHECKSUM_EN : frame carries a trailing XOR checksum word
//
// state  | meaning
// IDLE   | waiting for the first word of a frame (that word counts)
// LOAD   | collecting words of a frame
// COMMIT | one cycle with s_ready low; active bank takes the shadow bank
// DRAIN  | frame overran without s_last; discard words until s_last
module coef_frame_loader
  import coef_loader_pkg::*;
#(
  parameter int WHOLE_BITS = 10,
  parameter int FRAC_BITS  = 54,
  parameter int WIDTH      = WHOLE_BITS + FRAC_BITS,
  parameter int WORD_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_BITS-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     b0,
  output logic [WIDTH-1:0]     b1,
  output logic [WIDTH-1:0]     b2,
  output logic [WIDTH-1:0]     b3,
  output logic [WIDTH-1:0]     b4,
  output logic [WIDTH-1:0]     b5,
  output logic [WIDTH-1:0]     b6,
  output logic [WIDTH-1:0]     a3,
  output logic [WIDTH-1:0]     a6,
  output logic                 coefficients_ready,
  output logic                 load_error,
  output logic                 busy
);

  localparam int unsigned WPC         = words_per_coef(WIDTH, WORD_BITS);
  localparam int unsigned FRAME_WORDS = NUM_COEF * WPC;
`ifdef COEF_LOADER_CHECKSUM_EN
  localparam int unsigned TOTAL_WORDS = FRAME_WORDS + 1;
`else
  localparam int unsigned TOTAL_WORDS = FRAME_WORDS;
`endif
  localparam int unsigned CNT_W = $clog2(TOTAL_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(TOTAL_WORDS - 1);
  localparam logic [CNT_W-1:0] DATA_WORDS = CNT_W'(FRAME_WORDS);

  loader_state_e  state;
  logic [CNT_W-1:0] cnt;
  logic           cr_pend;
  logic           accept;
  logic           in_frame;
  logic           shadow_we;
  logic           sum_ok;
  logic [NUM_COEF-1:0][WIDTH-1:0] active;

  assign accept    = s_valid & s_ready;
  assign in_frame  = (state == IDLE) || (state == LOAD);
  assign shadow_we = in_frame & accept & (cnt < DATA_WORDS);
  assign busy      = (state != IDLE);

`ifdef COEF_LOADER_CHECKSUM_EN
  logic [WORD_BITS-1:0] csum;
  // Only consulted on the trailing word, by which point csum holds all data.
  assign sum_ok = (s_data == csum);
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      s_ready            <= 1'b0;
      load_error         <= 1'b0;
      coefficients_ready <= 1'b0;
      cr_pend            <= 1'b0;
`ifdef COEF_LOADER_CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      load_error <= 1'b0;
      s_ready    <= 1'b1;
      // coefficients_ready returns high one edge after the commit edge.
      if (cr_pend) begin
        coefficients_ready <= 1'b1;
        cr_pend            <= 1'b0;
      end
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
`ifdef COEF_LOADER_CHECKSUM_EN
            if (cnt == '0) begin
              csum <= s_data;
            end else if (cnt < DATA_WORDS) begin
              csum <= csum ^ s_data;
            end
`endif
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (!s_last) begin
                state <= DRAIN;
              end else if (sum_ok) begin
                state   <= COMMIT;
                s_ready <= 1'b0;
              end else begin
                state      <= IDLE;
                load_error <= 1'b1;
              end
            end else if (s_last) begin
              state      <= IDLE;
              cnt        <= '0;
              load_error <= 1'b1;
            end else begin
              state <= LOAD;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state              <= IDLE;
          coefficients_ready <= 1'b0;
          cr_pend            <= 1'b1;
        end
        DRAIN: begin
          if (accept && s_last) begin
            state      <= IDLE;
            load_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  coef_shadow_bank #(
    .WIDTH     (WIDTH),
    .WORD_BITS (WORD_BITS),
    .IDX_W     (CNT_W)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (shadow_we),
    .wr_idx  (cnt),
    .wr_data (s_data),
    .commit  (state == COMMIT),
    .active  (active)
  );

  assign b0 = active[B0];
  assign b1 = active[B1];
  assign b2 = active[B2];
  assign b3 = active[B3];
  assign b4 = active[B4];
  assign b5 = active[B5];
  assign b6 = active[B6];
  assign a3 = active[A3];
  assign a6 = active[A6];

endmodule
